// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: widths, reset vector, opcodes and instruction field positions.
package riscv_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_W   = 3;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int REG_W      = 5;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_W   = 7;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; storage is unreset, pointers and count reset asynchronously.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: credit-limited imem requests, registered instruction FIFO, redirect flush.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_flushed counters.
module instr_fetch_unit #(
    parameter int          XLEN      = riscv_pkg::XLEN_DEF,
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic [6:0]      if_opcode,
    output logic [2:0]      if_funct3,
    output logic [6:0]      if_funct7
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);
    import riscv_pkg::*;

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redirect_base;
    logic [CW-1:0]      outst_q, outst_d, drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop, credit_ok, req_hs;
    logic [XLEN+31:0]   fifo_rdata;

    assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};
    assign credit_ok      = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CW+1)'(BUF_DEPTH);
    // rst_n gates the request so nothing is offered while the core is held in reset.
    assign imem_req_valid = rst_n && credit_ok && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign fifo_pop       = if_valid && if_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_cnt_d = drop_cnt_q;
        fifo_push  = 1'b0;
        outst_d    = outst_q;
        if (req_hs)         outst_d = outst_d + CW'(1);
        if (imem_rsp_valid) outst_d = outst_d - CW'(1);
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            drop_cnt_d = outst_d;
        end else begin
            if (req_hs) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else begin
                    fifo_push = 1'b1;
                    rsp_pc_d  = rsp_pc_q + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= XLEN'(RESET_PC);
            rsp_pc_q   <= XLEN'(RESET_PC);
            outst_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({rsp_pc_q, imem_rsp_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign if_valid  = !fifo_empty;
    assign if_pc     = if_valid ? fifo_rdata[XLEN+31:32] : '0;
    assign if_instr  = if_valid ? fifo_rdata[31:0] : '0;
    assign if_opcode = if_instr[OPCODE_LSB +: OPCODE_W];
    assign if_funct3 = if_instr[FUNCT3_LSB +: FUNCT3_W];
    assign if_funct7 = if_instr[FUNCT7_LSB +: FUNCT7_W];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_flushed_q, perf_flushed_d, flush_amt;

    // Flushed = buffered entries not taken by decode plus newly orphaned in-flight requests.
    assign flush_amt = 32'(fifo_count) - 32'(fifo_pop) + 32'(outst_q) - 32'(drop_cnt_q);

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushed_d = perf_flushed_q;
        if (fifo_pop)       perf_fetched_d = sat_add32(perf_fetched_q, 32'd1);
        if (redirect_valid) perf_flushed_d = sat_add32(perf_flushed_q, flush_amt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`else
    logic unused_ok;
    assign unused_ok = fifo_full;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: request-tagged memory model, expected-instruction queue, directed corners.
module tb_instr_fetch_unit;

    localparam int          D      = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_instr;
    logic [6:0]  if_opcode, if_funct7;
    logic [2:0]  if_funct3;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .BUF_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .if_opcode(if_opcode), .if_funct3(if_funct3), .if_funct7(if_funct7)
    );

    typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] rpc; logic [31:0] pc; logic [6:0] op; logic [2:0] f3; logic [6:0] f7; } vec_t;

    mreq_t       mem_q[$];
    ent_t        exp_q[$];
    logic [31:0] pop_log[$];
    vec_t        vecs[5];
    int          tests = 0, fails = 0, cyc = 0, last_due = 0, lat = 1;
    logic [31:0] exp_fpc = RST_PC;
    bit          drv_req_ready = 1'b1, drv_if_ready = 1'b0, drv_redir = 1'b0, redir_on_busy = 1'b0;
    logic [31:0] drv_rpc = 32'h0;
    bit          s_req_valid, s_if_valid, s_hs, s_pop, s_rsp, s_redir;
    logic [31:0] s_addr, s_if_pc;
    logic [6:0]  s_op, s_f7;
    logic [2:0]  s_f3;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h000: return 32'h00500093;
            32'h200: return 32'h40208033;
            32'h204: return 32'h0020a023;
            32'h208: return 32'h00209463;
            32'h20c: return 32'h0040a103;
            default: return (a * 32'h9E3779B1) ^ 32'h0000_0013;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        mreq_t e;
        int    due;
        @(negedge clk);
        imem_req_ready = drv_req_ready;
        if_ready       = drv_if_ready;
        imem_rsp_valid = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_rsp_data  = imem_rsp_valid ? rom(mem_q[0].addr) : 32'h0;
        if (redir_on_busy && imem_rsp_valid && exp_q.size() != 0 && drv_if_ready) begin
            drv_redir     = 1'b1;
            redir_on_busy = 1'b0;
        end
        redirect_valid = drv_redir;
        redirect_pc    = drv_rpc;
        #1;
        s_req_valid = imem_req_valid;  s_addr = imem_req_addr;
        s_if_valid  = if_valid;        s_if_pc = if_pc;
        s_op = if_opcode; s_f3 = if_funct3; s_f7 = if_funct7;
        s_hs = s_req_valid && imem_req_ready;
        s_pop = s_if_valid && if_ready;
        s_rsp = imem_rsp_valid;
        s_redir = redirect_valid;
        chk("req_valid", 64'(s_req_valid), 64'((mem_q.size() + exp_q.size() < D) && !s_redir));
        chk("if_valid", 64'(s_if_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("if_pc", 64'(s_if_pc), 64'(exp_q[0].pc));
            chk("if_instr", 64'(if_instr), 64'(exp_q[0].instr));
            chk("if_opcode", 64'(s_op), 64'(exp_q[0].instr[6:0]));
            chk("if_funct3", 64'(s_f3), 64'(exp_q[0].instr[14:12]));
            chk("if_funct7", 64'(s_f7), 64'(exp_q[0].instr[31:25]));
        end else begin
            chk("if_pc_idle", 64'(s_if_pc), 64'h0);
        end
        if (s_req_valid) chk("req_addr", 64'(s_addr), 64'(exp_fpc));
        @(posedge clk);
        if (s_pop && exp_q.size() != 0) begin
            pop_log.push_back(s_if_pc);
            void'(exp_q.pop_front());
        end
        if (s_rsp) begin
            e = mem_q.pop_front();
            if (!e.stale && !s_redir) exp_q.push_back('{pc: e.addr, instr: rom(e.addr)});
        end
        if (s_redir) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_fpc = {drv_rpc[31:2], 2'b00};
        end else if (s_hs) begin
            exp_fpc = exp_fpc + 32'd4;
        end
        if (s_hs) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: s_addr, due: due, stale: s_redir});
        end
        chk("occupancy_within_credit", 64'(mem_q.size() + exp_q.size() <= D), 64'h1);
        cyc++;
        drv_redir = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
        chk("rst_if_valid", 64'(if_valid), 64'h0);
        chk("rst_if_pc", 64'(if_pc), 64'h0);
        chk("rst_if_instr", 64'(if_instr), 64'h0);
        mem_q.delete();
        exp_q.delete();
        exp_fpc  = RST_PC;
        last_due = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int          n;
        logic [31:0] a0, first_req;
        bit          seen_req;

        vecs[0] = '{rpc: 32'h202, pc: 32'h200, op: 7'b0110011, f3: 3'b000, f7: 7'b0100000};
        vecs[1] = '{rpc: 32'h207, pc: 32'h204, op: 7'b0100011, f3: 3'b010, f7: 7'b0000000};
        vecs[2] = '{rpc: 32'h208, pc: 32'h208, op: 7'b1100011, f3: 3'b001, f7: 7'b0000000};
        vecs[3] = '{rpc: 32'h20f, pc: 32'h20c, op: 7'b0000011, f3: 3'b010, f7: 7'b0000000};
        vecs[4] = '{rpc: 32'h003, pc: 32'h000, op: 7'b0010011, f3: 3'b000, f7: 7'b0000000};

        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
        do_reset();

        // Reset release, decode stalled: credit fills, first instruction is addi at 0
        step();
        chk("t1_first_req_valid", 64'(s_req_valid), 64'h1);
        chk("t1_first_req_addr", 64'(s_addr), 64'(RST_PC));
        repeat (9) step();
        chk("t2_credit_stall", 64'(s_req_valid), 64'h0);
        chk("t1_first_pc", 64'(s_if_pc), 64'h0);
        chk("t1_opcode", 64'(s_op), 64'h13);
        chk("t1_funct3", 64'(s_f3), 64'h0);
        chk("t1_funct7", 64'(s_f7), 64'h0);
        pop_log.delete();
        drv_if_ready = 1'b1;
        repeat (8) step();
        chk("t2_pops", 64'(pop_log.size() >= 3), 64'h1);
        if (pop_log.size() >= 3) begin
            chk("t2_pc0", 64'(pop_log[0]), 64'h0);
            chk("t2_pc1", 64'(pop_log[1]), 64'h4);
            chk("t2_pc2", 64'(pop_log[2]), 64'h8);
        end

        // Memory not ready: address held, one handshake on release
        drv_req_ready = 1'b0;
        n = 0;
        do begin step(); n++; end while (!s_req_valid && n < 20);
        chk("t3_pending", 64'(s_req_valid), 64'h1);
        a0 = s_addr;
        repeat (5) begin
            step();
            chk("t3_valid_held", 64'(s_req_valid), 64'h1);
            chk("t3_addr_held", 64'(s_addr), 64'(a0));
        end
        drv_req_ready = 1'b1;
        step();
        chk("t3_handshake", 64'(s_hs), 64'h1);
        chk("t3_hs_addr", 64'(s_addr), 64'(a0));

        // Redirect with two requests in flight, 3-cycle latency
        lat = 3;
        n = 0;
        while (mem_q.size() != 2 && n < 30) begin step(); n++; end
        chk("t4_two_inflight", 64'(mem_q.size()), 64'h2);
        drv_redir = 1'b1; drv_rpc = 32'h103;
        step();
        chk("t4_no_req_in_redirect", 64'(s_req_valid), 64'h0);
        pop_log.delete();
        seen_req = 1'b0; first_req = 32'h0; n = 0;
        while (pop_log.size() == 0 && n < 40) begin
            step(); n++;
            if (s_req_valid && !seen_req) begin seen_req = 1'b1; first_req = s_addr; end
        end
        chk("t4_first_req_addr", 64'(first_req), 64'h100);
        chk("t4_first_pop_seen", 64'(pop_log.size() != 0), 64'h1);
        if (pop_log.size() != 0) chk("t4_first_pc", 64'(pop_log[0]), 64'h100);

        // Redirect coinciding with a response and a pop
        lat = 1; drv_rpc = 32'h40; redir_on_busy = 1'b1;
        n = 0;
        do begin step(); n++; end while (!s_redir && n < 40);
        chk("t5_redirect_hit", 64'(s_redir), 64'h1);
        chk("t5_rsp_in_R", 64'(s_rsp), 64'h1);
        chk("t5_pop_in_R", 64'(s_pop), 64'h1);
        redir_on_busy = 1'b0;
        pop_log.delete();
        n = 0;
        while (pop_log.size() == 0 && n < 40) begin step(); n++; end
        chk("t5_first_pop_seen", 64'(pop_log.size() != 0), 64'h1);
        if (pop_log.size() != 0) chk("t5_first_pc", 64'(pop_log[0]), 64'h40);

        // Decode field table: redirect to known words and check the sliced fields
        lat = 2;
        for (int v = 0; v < 5; v++) begin
            drv_redir = 1'b1; drv_rpc = vecs[v].rpc;
            step();
            n = 0;
            do begin step(); n++; end while (!s_pop && n < 30);
            chk("vec_pop", 64'(s_pop), 64'h1);
            chk("vec_pc", 64'(s_if_pc), 64'(vecs[v].pc));
            chk("vec_opcode", 64'(s_op), 64'(vecs[v].op));
            chk("vec_funct3", 64'(s_f3), 64'(vecs[v].f3));
            chk("vec_funct7", 64'(s_f7), 64'(vecs[v].f7));
        end

        // Randomized traffic, stalls, latencies and redirects (including back-to-back drops)
        for (int i = 0; i < 1500; i++) begin
            lat           = $urandom_range(1, 4);
            drv_req_ready = ($urandom_range(0, 3) != 0);
            drv_if_ready  = ($urandom_range(0, 4) > 1);
            if ($urandom_range(0, 19) == 0) begin
                drv_redir = 1'b1;
                drv_rpc   = ($urandom_range(0, 99) == 0) ? 32'hFFFF_FFF9 : 32'($urandom_range(0, 4095));
            end
            step();
        end

        // Asynchronous reset mid-stream, then restart at the reset vector
        drv_req_ready = 1'b1; drv_if_ready = 1'b1; lat = 1;
        repeat (4) step();
        do_reset();
        step();
        chk("t6_restart_valid", 64'(s_req_valid), 64'h1);
        chk("t6_restart_addr", 64'(s_addr), 64'(RST_PC));
        pop_log.delete();
        repeat (6) step();
        chk("t6_pops", 64'(pop_log.size() != 0), 64'h1);
        if (pop_log.size() != 0) chk("t6_first_pc", 64'(pop_log[0]), 64'(RST_PC));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
